// File: rtl/song_recorder_pkg.sv
// Shared codes for the song recorder: FSM states, octave and rest codes,
// plus the key-sample encoder and event-to-tone decoder used by the top.
package song_recorder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } state_t;

    localparam logic [1:0] OCT_MID   = 2'd0;
    localparam logic [1:0] OCT_HIGH  = 2'd1;
    localparam logic [1:0] OCT_LOW   = 2'd2;
    localparam logic [2:0] NOTE_REST = 3'd0;

    typedef struct packed {
        logic [2:0] note;
        logic [1:0] oct;
    } key_t;

    typedef struct packed {
        logic [6:0] notes;
        logic       higher;
        logic       lower;
    } tone_t;

    // Anything other than one note key with at most one octave switch is a rest.
    function automatic key_t encode_keys(input logic [6:0] notes,
                                         input logic       higher,
                                         input logic       lower);
        key_t k;
        k.note = NOTE_REST;
        k.oct  = OCT_MID;
        if (!(higher && lower)) begin
            case (notes)
                7'b1000000: k.note = 3'd1;
                7'b0100000: k.note = 3'd2;
                7'b0010000: k.note = 3'd3;
                7'b0001000: k.note = 3'd4;
                7'b0000100: k.note = 3'd5;
                7'b0000010: k.note = 3'd6;
                7'b0000001: k.note = 3'd7;
                default:    k.note = NOTE_REST;
            endcase
        end
        if (k.note != NOTE_REST)
            k.oct = higher ? OCT_HIGH : (lower ? OCT_LOW : OCT_MID);
        return k;
    endfunction

    function automatic tone_t decode_key(input key_t k);
        tone_t t;
        t = '0;
        if (k.note != NOTE_REST) begin
            t.notes  = 7'b1000000 >> (k.note - 3'd1);
            t.higher = (k.oct == OCT_HIGH);
            t.lower  = (k.oct == OCT_LOW);
        end
        return t;
    endfunction

endpackage

// File: rtl/song_recorder_tick_gen.sv
// Free-running duration prescaler; clr restarts the period from zero.
// Latency: tick is high in the last cycle of each TICK_CYC-cycle period.
// Backpressure: none, tick is a bare pulse.
module song_recorder_tick_gen #(
    parameter int unsigned TICK_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_CYC + 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset || clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/song_recorder.sv
// Records note-key performances as {note,oct,dur} events and replays them.
// Latency: outputs registered, one cycle after keys or event changes.
// Backpressure: none; control pulses not legal in the current state are dropped.
module song_recorder
    import song_recorder_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_MS = 10,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned DUR_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [6:0]               notes,
    input  logic                     ishigher,
    input  logic                     islower,
    input  logic                     rec_start,
    input  logic                     play_start,
    input  logic                     stop,
    output logic [6:0]               notes_out,
    output logic                     higher_out,
    output logic                     lower_out,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     rec_full,
    output logic                     play_done
);

    localparam int unsigned TICK_CYC = CLK_HZ / 1000 * TICK_MS;
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [DUR_W-1:0] DUR_MAX = '1;

    typedef struct packed {
        key_t             key;
        logic [DUR_W-1:0] dur;
    } event_t;

    state_t           st;
    event_t           mem [DEPTH];
    key_t             sample;
    key_t             cur_key;
    logic [DUR_W-1:0] cur_dur;
    logic             cur_valid;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_addr;
    logic [DUR_W-1:0] ticks_left;
    event_t           rd_ev;
    event_t           wr_ev;
    logic             wr_en;
    logic             tick;
    logic             tick_clr;
    tone_t            pass_tone;
    tone_t            tone_q;

    assign sample     = encode_keys(notes, ishigher, islower);
    assign pass_tone  = decode_key(sample);
    assign state      = st;
    assign notes_out  = tone_q.notes;
    assign higher_out = tone_q.higher;
    assign lower_out  = tone_q.lower;

    // Prescaler restarts exactly when RECORD or PLAY is entered.
    assign tick_clr = (st == ST_IDLE) &&
                      (rec_start || (play_start && count != '0));

    song_recorder_tick_gen #(
        .TICK_CYC (TICK_CYC)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .tick  (tick)
    );

    // Pending event closes on stop, on a key change, or on duration saturation.
    always_comb begin
        wr_en     = 1'b0;
        wr_ev.key = cur_key;
        wr_ev.dur = cur_dur;
        if (st == ST_RECORD && cur_valid) begin
            if (stop)
                wr_en = 1'b1;
            else if (tick && !(sample == cur_key && cur_dur != DUR_MAX))
                wr_en = 1'b1;
        end
    end

    assign rd_addr = (st == ST_PLAY) ? rd_ptr + 1'b1 : '0;
    assign rd_ev   = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[count[AW-1:0]] <= wr_ev;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= ST_IDLE;
            count      <= '0;
            rec_full   <= 1'b0;
            cur_valid  <= 1'b0;
            cur_key    <= '0;
            cur_dur    <= '0;
            rd_ptr     <= '0;
            ticks_left <= '0;
            play_done  <= 1'b0;
            tone_q     <= '0;
        end else begin
            play_done <= 1'b0;
            tone_q    <= pass_tone;
            case (st)
                ST_IDLE: begin
                    if (rec_start) begin
                        st        <= ST_RECORD;
                        count     <= '0;
                        rec_full  <= 1'b0;
                        cur_valid <= 1'b0;
                    end else if (play_start && count != '0) begin
                        st         <= ST_PLAY;
                        rd_ptr     <= '0;
                        ticks_left <= rd_ev.dur;
                        tone_q     <= decode_key(rd_ev.key);
                    end
                end
                ST_RECORD: begin
                    if (wr_en)
                        count <= count + 1'b1;
                    if (stop) begin
                        st        <= ST_IDLE;
                        cur_valid <= 1'b0;
                    end else if (tick) begin
                        if (!cur_valid) begin
                            cur_key   <= sample;
                            cur_dur   <= DUR_W'(1);
                            cur_valid <= 1'b1;
                        end else if (!wr_en) begin
                            cur_dur <= cur_dur + 1'b1;
                        end else if (count == CNT_W'(DEPTH - 1)) begin
                            st        <= ST_IDLE;
                            rec_full  <= 1'b1;
                            cur_valid <= 1'b0;
                        end else begin
                            cur_key <= sample;
                            cur_dur <= DUR_W'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    if (stop) begin
                        st <= ST_IDLE;
                    end else begin
                        tone_q <= tone_q;
                        if (tick) begin
                            if (ticks_left > DUR_W'(1)) begin
                                ticks_left <= ticks_left - 1'b1;
                            end else if ({1'b0, rd_ptr} == count - 1'b1) begin
                                st        <= ST_IDLE;
                                play_done <= 1'b1;
                                tone_q    <= pass_tone;
                            end else begin
                                rd_ptr     <= rd_ptr + 1'b1;
                                ticks_left <= rd_ev.dur;
                                tone_q     <= decode_key(rd_ev.key);
                            end
                        end
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule
